// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer and its datapath.
// Mode 0 only: SCLK idles low and data is sampled on the rising edge.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } spi_state_e;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Counter width for a modulus n; a 1-cycle modulus still needs one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/shift_reg.sv
// Parallel-load, left-shifting register: serial_out is the MSB and
// serial_in enters at the LSB, so a full word shifts out MSB first.
module shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             serial_out
);

    logic [WIDTH-1:0] data_r;

    // Load has priority; the controller never asserts both together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {WIDTH{1'b0}};
        end else if (load_en) begin
            data_r <= d_in;
        end else if (shift_en) begin
            data_r <= {data_r[WIDTH-2:0], serial_in};
        end
    end

    assign d_out      = data_r;
    assign serial_out = data_r[WIDTH-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master sequencer: handshakes a word in, clocks it out on mosi
// while sampling miso, and returns the received word with a one-cycle pulse.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_LEN = 8,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                sclk,
    output logic                cs_n,
    output logic                mosi,
    input  logic                miso
);

    localparam int HCW = cnt_width(CLK_DIV);
    localparam int ECW = $clog2(2 * DATA_LEN + 1);
    localparam logic [HCW-1:0] HC_MAX   = HCW'(CLK_DIV - 1);
    localparam logic [ECW-1:0] EDGE_MAX = ECW'(2 * DATA_LEN);

    spi_state_e          state_r;
    spi_state_e          state_s;
    logic [HCW-1:0]      hcnt_r;
    logic [ECW-1:0]      ecnt_r;
    logic                sclk_r;
    logic                miso_q_r;
    logic                cs_n_r;
    logic                busy_r;
    logic                tx_ready_r;
    logic                rx_valid_r;
    logic [DATA_LEN-1:0] rx_data_r;

    logic                wrap_s;
    logic                toggle_s;
    logic                rise_s;
    logic                fall_s;
    logic                load_en_s;
    logic                shift_en_s;
    logic                sr_rst_s;
    logic [DATA_LEN-1:0] d_out_s;
    logic                serial_out_s;

    // SCLK edge decode. The SETUP wrap produces the first rising edge; XFER
    // wraps produce the rest until 2*DATA_LEN edges have been issued.
    always_comb begin
        wrap_s   = (hcnt_r == HC_MAX);
        toggle_s = 1'b0;
        if (wrap_s && (state_r == SETUP)) begin
            toggle_s = 1'b1;
        end else if (wrap_s && (state_r == XFER) && (ecnt_r < EDGE_MAX)) begin
            toggle_s = 1'b1;
        end else begin
            toggle_s = 1'b0;
        end
        rise_s     = toggle_s && !sclk_r;
        fall_s     = toggle_s && sclk_r;
        load_en_s  = (state_r == IDLE) && tx_valid;
        shift_en_s = fall_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = load_en_s ? SETUP : IDLE;
            SETUP:   state_s = wrap_s ? XFER : SETUP;
            XFER:    state_s = (wrap_s && (ecnt_r == EDGE_MAX)) ? DONE : XFER;
            DONE:    state_s = wrap_s ? IDLE : DONE;
            default: state_s = IDLE;
        endcase
    end

    // State, half-period and edge counters, SCLK and the miso sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            hcnt_r   <= {HCW{1'b0}};
            ecnt_r   <= {ECW{1'b0}};
            sclk_r   <= CPOL;
            miso_q_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) || wrap_s) begin
                hcnt_r <= {HCW{1'b0}};
            end else begin
                hcnt_r <= hcnt_r + HCW'(1);
            end
            if (state_r == IDLE) begin
                ecnt_r <= {ECW{1'b0}};
            end else if (toggle_s) begin
                ecnt_r <= ecnt_r + ECW'(1);
            end
            if (toggle_s) begin
                sclk_r <= !sclk_r;
            end
            if (rise_s) begin
                miso_q_r <= miso;
            end
        end
    end

    // Registered status outputs, derived from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_n_r     <= 1'b1;
            busy_r     <= 1'b0;
            tx_ready_r <= 1'b1;
            rx_valid_r <= 1'b0;
            rx_data_r  <= {DATA_LEN{1'b0}};
        end else begin
            cs_n_r     <= (state_s == IDLE);
            busy_r     <= (state_s != IDLE);
            tx_ready_r <= (state_s == IDLE);
            rx_valid_r <= (state_r == DONE) && (state_s == IDLE);
            if ((state_r == DONE) && (state_s == IDLE)) begin
                rx_data_r <= d_out_s;
            end
        end
    end

    assign sr_rst_s = !rst;

    shift_reg #(
        .WIDTH (DATA_LEN)
    ) u_shift_reg (
        .clk        (clk),
        .rst        (sr_rst_s),
        .load_en    (load_en_s),
        .shift_en   (shift_en_s),
        .serial_in  (miso_q_r),
        .d_in       (tx_data),
        .d_out      (d_out_s),
        .serial_out (serial_out_s)
    );

    // Gating with cs_n keeps mosi low outside a transfer whatever the register holds.
    assign mosi     = serial_out_s && !cs_n_r;
    assign sclk     = sclk_r;
    assign cs_n     = cs_n_r;
    assign busy     = busy_r;
    assign tx_ready = tx_ready_r;
    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: default instance plus a CLK_DIV=1 instance,
// both with hand-computed expected cycle positions and words.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] tx_data0, rx_data0, tx_data1, rx_data1;
    logic       tx_valid0, tx_ready0, rx_valid0, busy0, sclk0, cs_n0, mosi0, miso0;
    logic       tx_valid1, tx_ready1, rx_valid1, busy1, sclk1, cs_n1, mosi1, miso1;
    logic       loop_en, miso_fix;

    assign miso0 = loop_en ? mosi0 : miso_fix;
    assign miso1 = mosi1;

    spi_master_ctrl #(.DATA_LEN(8), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0), .sclk(sclk0), .cs_n(cs_n0),
        .mosi(mosi0), .miso(miso0)
    );

    spi_master_ctrl #(.DATA_LEN(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1), .cs_n(cs_n1),
        .mosi(mosi1), .miso(miso1)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc, rises, first_rise, second_rise, rxv_n, rxv_cyc, cs_high_n, ready_bad;
    logic [7:0] mosi_bits, rxv_data;
    logic       rxv_cs_n, sclk0_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; rises = 0; first_rise = -1; second_rise = -1;
        rxv_n = 0; rxv_cyc = -1; cs_high_n = 0; ready_bad = 0;
        mosi_bits = 8'h00; rxv_data = 8'h00; rxv_cs_n = 1'b0;
    endtask

    // One cycle on the default instance, sampled on the falling clock edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (sclk0 && !sclk0_prev && !cs_n0) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], mosi0};
            if (first_rise < 0) first_rise = cyc;
            else if (second_rise < 0) second_rise = cyc;
        end
        if (rx_valid0) begin
            rxv_n++;
            rxv_cyc  = cyc;
            rxv_data = rx_data0;
            rxv_cs_n = cs_n0;
        end
        if (cyc >= 2 && cs_n0) cs_high_n++;
        if (busy0 && tx_ready0) ready_bad++;
        sclk0_prev = sclk0;
    endtask

    // Presents a word; the following rising edge (cycle 1) is the handshake edge.
    task automatic start0(input logic [7:0] d);
        clear_stats();
        tx_data0  = d;
        tx_valid0 = 1'b1;
        step();
    endtask

    task automatic wait_rx(input int n, input int limit);
        while (rxv_n < n && cyc < limit) step();
    endtask

    int         c1, tog, first1, last1, rx1c;
    logic [7:0] rx1d;
    logic       prev1;

    initial begin
        rst = 1'b0; loop_en = 1'b1; miso_fix = 1'b0; sclk0_prev = 1'b0;
        tx_valid0 = 1'b0; tx_data0 = 8'h00; tx_valid1 = 1'b0; tx_data1 = 8'h00;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready0), 32'd1);
        check("rst_busy",     32'(busy0),     32'd0);
        check("rst_cs_n",     32'(cs_n0),     32'd1);
        check("rst_sclk",     32'(sclk0),     32'd0);
        check("rst_mosi",     32'(mosi0),     32'd0);
        check("rst_rx_valid", 32'(rx_valid0), 32'd0);
        check("rst_rx_data",  32'(rx_data0),  32'd0);
        rst = 1'b1;
        step();

        // Loopback B3
        start0(8'hB3);
        tx_valid0 = 1'b0;
        check("b3_cs_fall",  32'(cs_n0), 32'd0);
        check("b3_busy",     32'(busy0), 32'd1);
        wait_rx(1, 200);
        check("b3_first_rise", first_rise, 32'd5);
        check("b3_sclk_per",   second_rise, 32'd13);
        check("b3_rises",      rises, 32'd8);
        check("b3_mosi_bits",  32'(mosi_bits), 32'hB3);
        check("b3_rxv_cyc",    rxv_cyc, 32'd73);
        check("b3_rx_data",    32'(rxv_data), 32'hB3);
        check("b3_rxv_cs_n",   32'(rxv_cs_n), 32'd1);
        step();
        check("b3_rxv_pulse",  32'(rx_valid0), 32'd0);

        // miso stuck at 1, transmit 00
        loop_en = 1'b0; miso_fix = 1'b1;
        start0(8'h00);
        tx_valid0 = 1'b0;
        wait_rx(1, 200);
        check("ff_rises",   rises, 32'd8);
        check("ff_rx_data", 32'(rxv_data), 32'hFF);
        check("ff_rxv_cyc", rxv_cyc, 32'd73);
        loop_en = 1'b1;
        repeat (3) step();

        // Back-to-back A5 then 3C with tx_valid held
        start0(8'hA5);
        tx_data0 = 8'h3C;
        wait_rx(1, 200);
        check("bb_rxv1_cyc",  rxv_cyc, 32'd73);
        check("bb_rx1",       32'(rxv_data), 32'hA5);
        check("bb_ready_rxv", 32'(tx_ready0), 32'd1);
        step();
        check("bb_cs_relow",  32'(cs_n0), 32'd0);
        check("bb_cs_high_n", cs_high_n, 32'd1);
        tx_valid0 = 1'b0;
        wait_rx(2, 300);
        check("bb_rxv2_cyc",  rxv_cyc, 32'd146);
        check("bb_rx2",       32'(rxv_data), 32'h3C);
        repeat (3) step();

        // tx_valid pulse with FF during XFER must be ignored
        start0(8'h96);
        tx_valid0 = 1'b0;
        while (cyc < 20) step();
        tx_data0 = 8'hFF; tx_valid0 = 1'b1;
        step();
        check("ign_ready", 32'(tx_ready0), 32'd0);
        tx_valid0 = 1'b0;
        wait_rx(1, 200);
        check("ign_rx_data",   32'(rxv_data), 32'h96);
        check("ign_rxv_cyc",   rxv_cyc, 32'd73);
        check("ign_ready_bad", ready_bad, 32'd0);
        repeat (3) step();
        check("ign_no_restart", 32'(busy0), 32'd0);

        // Reset after the 4th rising edge of a 1F transfer
        start0(8'h1F);
        tx_valid0 = 1'b0;
        while (rises < 4 && cyc < 200) step();
        check("ab_rises", rises, 32'd4);
        check("ab_sclk_hi", 32'(sclk0), 32'd1);
        check("ab_mosi_hi", 32'(mosi0), 32'd1);
        rst = 1'b0;
        #1;
        check("ab_sclk",  32'(sclk0),     32'd0);
        check("ab_cs_n",  32'(cs_n0),     32'd1);
        check("ab_mosi",  32'(mosi0),     32'd0);
        check("ab_busy",  32'(busy0),     32'd0);
        check("ab_ready", 32'(tx_ready0), 32'd1);
        check("ab_rxd",   32'(rx_data0),  32'd0);
        step(); step();
        rst = 1'b1;
        repeat (100) step();
        check("ab_no_rxv", rxv_n, 32'd0);
        start0(8'h5A);
        tx_valid0 = 1'b0;
        wait_rx(1, 200);
        check("ab_5a_cyc", rxv_cyc, 32'd73);
        check("ab_5a",     32'(rxv_data), 32'h5A);

        // CLK_DIV=1 loopback 81
        @(negedge clk);
        tx_data1 = 8'h81; tx_valid1 = 1'b1;
        @(negedge clk);
        c1 = 1; tx_valid1 = 1'b0; prev1 = sclk1;
        tog = 0; first1 = -1; last1 = -1; rx1c = -1; rx1d = 8'h00;
        while (rx1c < 0 && c1 < 60) begin
            @(negedge clk);
            c1++;
            if (sclk1 != prev1) begin
                tog++;
                if (first1 < 0) first1 = c1;
                last1 = c1;
            end
            prev1 = sclk1;
            if (rx_valid1) begin
                rx1c = c1;
                rx1d = rx_data1;
            end
        end
        check("d1_first_tog", first1, 32'd2);
        check("d1_last_tog",  last1,  32'd17);
        check("d1_toggles",   tog,    32'd16);
        check("d1_rxv_cyc",   rx1c,   32'd19);
        check("d1_rx_data",   32'(rx1d), 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
